stb_dcache_drain: RTL and testbench

Drain controller downstream of the store buffer FIFO. Pops the oldest committed store from the store buffer, holds it in an output register, and presents it to the data cache over a req/ack write handshake until accepted. Gives LSU writes priority over pops, except during a fence, which forces a full drain and reports completion.

---
 rtl/stb_pkg.sv | 26 ++
 rtl/sat_counter.sv | 31 +++
 rtl/stb_dcache_drain.sv | 121 ++++++++++++
 tb/tb_stb_dcache_drain.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stb_pkg : shared widths, store-entry type and drain FSM states             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package stb_pkg;

  localparam int STB_ADDR_W = 8;
  localparam int STB_DATA_W = 16;
  localparam int STB_SEL_W  = 4;
  localparam int STB_PERF_W = 16;

  typedef struct packed {
    logic [STB_ADDR_W-1:0] addr;
    logic [STB_DATA_W-1:0] wdata;
    logic [STB_SEL_W-1:0]  sel_byte;
  } stb_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    REQ  = 2'd2
  } drain_state_e;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at all-ones; clear beats increment    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/stb_dcache_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stb_dcache_drain : pops store-buffer head, presents it to dcache req/ack.  |
// | Optional perf counters with STB_DRAIN_PERF_EN.           Rev 1.0           |
// +----------------------------------------------------------------------------+
module stb_dcache_drain
  import stb_pkg::*;
#(
  parameter int DATA_W = STB_DATA_W,
  parameter int ADDR_W = STB_ADDR_W,
  parameter int SEL_W  = STB_SEL_W
`ifdef STB_DRAIN_PERF_EN
  ,
  parameter int PERF_W = STB_PERF_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stb_empty,
  input  logic              lsummu2stb_wr_en,
  input  logic [ADDR_W-1:0] stb2dcache_addr,
  input  logic [DATA_W-1:0] stb2dcache_wdata,
  input  logic [SEL_W-1:0]  stb2dcache_sel_byte,
  output logic              stb_rd_sel,
  output logic              dcache_req,
  output logic [ADDR_W-1:0] dcache_addr,
  output logic [DATA_W-1:0] dcache_wdata,
  output logic [SEL_W-1:0]  dcache_sel_byte,
  input  logic              dcache_ack,
  input  logic              fence_req,
  output logic              fence_ack
`ifdef STB_DRAIN_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [PERF_W-1:0] perf_drained,
  output logic [PERF_W-1:0] perf_stall
`endif
);

  drain_state_e      state_q;
  logic              rd_sel_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SEL_W-1:0]  sel_q;
  logic              can_pop;

  // LSU writes own the store-buffer port unless a fence is draining it
  assign can_pop = !stb_empty && (!lsummu2stb_wr_en || fence_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_sel_q <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (can_pop) begin
            state_q  <= POP;
            rd_sel_q <= 1'b1;
          end
        end
        POP: begin
          state_q  <= REQ;
          rd_sel_q <= 1'b0;
          req_q    <= 1'b1;
          addr_q   <= stb2dcache_addr;
          wdata_q  <= stb2dcache_wdata;
          sel_q    <= stb2dcache_sel_byte;
        end
        REQ: begin
          if (dcache_ack) begin
            req_q <= 1'b0;
            if (can_pop) begin
              state_q  <= POP;
              rd_sel_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          rd_sel_q <= 1'b0;
          req_q    <= 1'b0;
        end
      endcase
    end
  end

  assign stb_rd_sel      = rd_sel_q;
  assign dcache_req      = req_q;
  assign dcache_addr     = addr_q;
  assign dcache_wdata    = wdata_q;
  assign dcache_sel_byte = sel_q;
  assign fence_ack       = fence_req && stb_empty && (state_q == IDLE);

`ifdef STB_DRAIN_PERF_EN
  sat_counter #(.W(PERF_W)) u_cnt_drained (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (req_q && dcache_ack),
    .clr   (perf_clr),
    .count (perf_drained)
  );

  sat_counter #(.W(PERF_W)) u_cnt_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (req_q && !dcache_ack),
    .clr   (perf_clr),
    .count (perf_stall)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_stb_dcache_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_stb_dcache_drain : store-buffer queue model + drain reference model     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_stb_dcache_drain;
  import stb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stb_empty;
  logic        wr_en;
  logic [7:0]  h_addr;
  logic [15:0] h_wdata;
  logic [3:0]  h_sel;
  logic        stb_rd_sel;
  logic        dcache_req;
  logic [7:0]  dcache_addr;
  logic [15:0] dcache_wdata;
  logic [3:0]  dcache_sel_byte;
  logic        ack;
  logic        fence;
  logic        fence_ack;
  logic        perf_clr;
`ifdef STB_DRAIN_PERF_EN
  logic [15:0] perf_drained;
  logic [15:0] perf_stall;
`endif

  stb_dcache_drain dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .stb_empty           (stb_empty),
    .lsummu2stb_wr_en    (wr_en),
    .stb2dcache_addr     (h_addr),
    .stb2dcache_wdata    (h_wdata),
    .stb2dcache_sel_byte (h_sel),
    .stb_rd_sel          (stb_rd_sel),
    .dcache_req          (dcache_req),
    .dcache_addr         (dcache_addr),
    .dcache_wdata        (dcache_wdata),
    .dcache_sel_byte     (dcache_sel_byte),
    .dcache_ack          (ack),
    .fence_req           (fence),
    .fence_ack           (fence_ack)
`ifdef STB_DRAIN_PERF_EN
    ,
    .perf_clr            (perf_clr),
    .perf_drained        (perf_drained),
    .perf_stall          (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference: store buffer contents, "pop strobe due", "entry being presented"
  stb_entry_t  sbq[$];
  bit          m_pop;
  bit          m_present;
  stb_entry_t  m_out;
  logic [15:0] m_drained;
  logic [15:0] m_stall;

  function automatic stb_entry_t rand_entry();
    stb_entry_t e;
    e.addr     = 8'($urandom);
    e.wdata    = 16'($urandom);
    e.sel_byte = 4'($urandom);
    return e;
  endfunction

  task automatic refresh_head();
    stb_empty = (sbq.size() == 0);
    if (sbq.size() != 0) begin
      h_addr  = sbq[0].addr;
      h_wdata = sbq[0].wdata;
      h_sel   = sbq[0].sel_byte;
    end else begin
      h_addr  = 8'($urandom);
      h_wdata = 16'($urandom);
      h_sel   = 4'($urandom);
    end
  endtask

  task automatic model_reset();
    m_pop     = 1'b0;
    m_present = 1'b0;
    m_out     = '0;
    m_drained = '0;
    m_stall   = '0;
    sbq.delete();
  endtask

  // One clock: advance the model on the edge, then refresh store-buffer head.
  task automatic tick();
    bit cp;
    bit was_req;
    @(posedge clk);
    cp      = (sbq.size() != 0) && (!wr_en || fence);
    was_req = m_present;
    if (perf_clr) begin
      m_drained = '0;
      m_stall   = '0;
    end else if (was_req && ack && m_drained != 16'hFFFF) begin
      m_drained = m_drained + 16'd1;
    end else if (was_req && !ack && m_stall != 16'hFFFF) begin
      m_stall = m_stall + 16'd1;
    end
    if (m_pop) begin
      m_out     = sbq.pop_front();
      m_pop     = 1'b0;
      m_present = 1'b1;
    end else if (m_present) begin
      if (ack) begin
        m_present = 1'b0;
        m_pop     = cp;
      end
    end else begin
      m_pop = cp;
    end
    if (wr_en) sbq.push_back(rand_entry());
    @(negedge clk);
    refresh_head();
    #1;
  endtask

  task automatic settle_idle();
    wr_en = 0; fence = 0; ack = 1; perf_clr = 0;
    for (int c = 0; c < 60 && (m_pop || m_present || sbq.size() != 0); c++) tick();
    ack = 0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; wr_en = 0; fence = 0; ack = 0; perf_clr = 0;
    model_reset();
    refresh_head();
    #1;
    vecs++;
    if ({stb_rd_sel, dcache_req, fence_ack} !== 3'b000) begin
      errs++; $display("FAIL reset_ctl: got %b exp 000", {stb_rd_sel, dcache_req, fence_ack});
    end
    vecs++;
    if ({dcache_addr, dcache_wdata, dcache_sel_byte} !== 28'h0) begin
      errs++; $display("FAIL reset_data: got %h exp 0", {dcache_addr, dcache_wdata, dcache_sel_byte});
    end
`ifdef STB_DRAIN_PERF_EN
    vecs++;
    if ({perf_drained, perf_stall} !== 32'h0) begin
      errs++; $display("FAIL reset_perf: got %h exp 0", {perf_drained, perf_stall});
    end
`endif
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic test_single();
    stb_entry_t e;
    e = '{addr: 8'h12, wdata: 16'hBEEF, sel_byte: 4'b0011};
    sbq.push_back(e);
    refresh_head();
    #1;
    tick();
    vecs++;
    if (stb_rd_sel !== 1'b1 || dcache_req !== 1'b0) begin
      errs++; $display("FAIL single_pop: got rd_sel=%b req=%b exp 1 0", stb_rd_sel, dcache_req);
    end
    ack = 1;
    tick();
    vecs++;
    if ({dcache_req, dcache_addr, dcache_wdata, dcache_sel_byte} !== {1'b1, 8'h12, 16'hBEEF, 4'b0011}) begin
      errs++; $display("FAIL single_req: got %b %h %h %b exp 1 12 beef 0011",
                       dcache_req, dcache_addr, dcache_wdata, dcache_sel_byte);
    end
    tick();
    ack = 0;
    #1;
    vecs++;
    if ({stb_rd_sel, dcache_req} !== 2'b00) begin
      errs++; $display("FAIL single_idle: got %b exp 00", {stb_rd_sel, dcache_req});
    end
  endtask

  task automatic test_stall();
    logic [27:0] held;
    perf_clr = 1;
    tick();
    perf_clr = 0;
    sbq.push_back(rand_entry());
    refresh_head();
    #1;
    tick();
    tick();
    held = {m_out.addr, m_out.wdata, m_out.sel_byte};
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (dcache_req !== 1'b1 || {dcache_addr, dcache_wdata, dcache_sel_byte} !== held) begin
        errs++; $display("FAIL stall_hold[%0d]: got req=%b data=%h exp req=1 data=%h",
                         i, dcache_req, {dcache_addr, dcache_wdata, dcache_sel_byte}, held);
      end
      tick();
    end
    ack = 1;
    tick();
    ack = 0;
    #1;
    vecs++;
    if (dcache_req !== 1'b0) begin
      errs++; $display("FAIL stall_release: got req=%b exp 0", dcache_req);
    end
`ifdef STB_DRAIN_PERF_EN
    vecs++;
    if (perf_stall !== 16'd5 || perf_drained !== 16'd1) begin
      errs++; $display("FAIL stall_perf: got stall=%0d drained=%0d exp 5 1", perf_stall, perf_drained);
    end
`endif
  endtask

  task automatic test_lsu_priority();
    sbq.push_back(rand_entry());
    refresh_head();
    wr_en = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (stb_rd_sel !== 1'b0) begin
        errs++; $display("FAIL lsu_defer[%0d]: got rd_sel=%b exp 0", i, stb_rd_sel);
      end
    end
    wr_en = 0;
    tick();
    vecs++;
    if (stb_rd_sel !== 1'b1) begin
      errs++; $display("FAIL lsu_resume: got rd_sel=%b exp 1", stb_rd_sel);
    end
    settle_idle();
  endtask

  task automatic test_fence();
    int pulses = 0;
    for (int i = 0; i < 3; i++) sbq.push_back(rand_entry());
    refresh_head();
    fence = 1;
    wr_en = 1;
    #1;
    tick();
    vecs++;
    if (stb_rd_sel !== 1'b1) begin
      errs++; $display("FAIL fence_pop: got rd_sel=%b exp 1", stb_rd_sel);
    end
    tick();
    tick();
    wr_en = 0;
    ack = 1;
    #1;
    for (int c = 0; c < 40 && (m_pop || m_present || sbq.size() != 0); c++) begin
      if (fence_ack === 1'b1) pulses++;
      tick();
    end
    vecs++;
    if (pulses != 0 || fence_ack !== 1'b1) begin
      errs++; $display("FAIL fence_done: got early=%0d ack=%b exp 0 1", pulses, fence_ack);
    end
    fence = 0;
    ack = 0;
    #1;
    vecs++;
    if (fence_ack !== 1'b0) begin
      errs++; $display("FAIL fence_drop: got %b exp 0", fence_ack);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] seen = '0;
    perf_clr = 1;
    tick();
    perf_clr = 0;
    for (int i = 0; i < 4; i++) sbq.push_back(rand_entry());
    refresh_head();
    ack = 1;
    #1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      seen[k] = stb_rd_sel;
    end
    ack = 0;
    vecs++;
    if (seen !== 10'b0010101010) begin
      errs++; $display("FAIL b2b_pops: got %b exp 0010101010", seen);
    end
`ifdef STB_DRAIN_PERF_EN
    vecs++;
    if (perf_drained !== 16'd4) begin
      errs++; $display("FAIL b2b_perf: got %0d exp 4", perf_drained);
    end
`endif
  endtask

  task automatic test_reset_mid_req();
    sbq.push_back(rand_entry());
    refresh_head();
    #1;
    tick();
    tick();
    vecs++;
    if (dcache_req !== 1'b1) begin
      errs++; $display("FAIL midreq_pre: got req=%b exp 1", dcache_req);
    end
    rst_n = 0;
    #1;
    vecs++;
    if ({stb_rd_sel, dcache_req, dcache_addr, dcache_wdata, dcache_sel_byte} !== 30'h0) begin
      errs++; $display("FAIL midreq_async: got %h exp 0",
                       {stb_rd_sel, dcache_req, dcache_addr, dcache_wdata, dcache_sel_byte});
    end
    model_reset();
    refresh_head();
    @(negedge clk);
    rst_n = 1;
    #1;
    tick();
    vecs++;
    if ({stb_rd_sel, dcache_req} !== 2'b00) begin
      errs++; $display("FAIL midreq_idle: got %b exp 00", {stb_rd_sel, dcache_req});
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      wr_en    = (sbq.size() < 6) && ($urandom_range(0, 9) < 3);
      fence    = ($urandom_range(0, 9) == 0);
      ack      = $urandom_range(0, 1) == 1;
      perf_clr = ($urandom_range(0, 31) == 0);
      #1;
      vecs++;
      if ({stb_rd_sel, dcache_req, fence_ack} !==
          {m_pop, m_present, fence && sbq.size() == 0 && !m_pop && !m_present}) begin
        errs++; $display("FAIL rand_ctl@%0d: got %b exp %b", c, {stb_rd_sel, dcache_req, fence_ack},
                         {m_pop, m_present, fence && sbq.size() == 0 && !m_pop && !m_present});
      end
      vecs++;
      if ({dcache_addr, dcache_wdata, dcache_sel_byte} !== m_out) begin
        errs++; $display("FAIL rand_data@%0d: got %h exp %h", c,
                         {dcache_addr, dcache_wdata, dcache_sel_byte}, m_out);
      end
`ifdef STB_DRAIN_PERF_EN
      vecs++;
      if (perf_drained !== m_drained || perf_stall !== m_stall) begin
        errs++; $display("FAIL rand_perf@%0d: got %0d/%0d exp %0d/%0d", c,
                         perf_drained, perf_stall, m_drained, m_stall);
      end
`endif
      tick();
    end
    settle_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_lsu_priority();
    test_fence();
    test_back_to_back();
    test_reset_mid_req();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
